// File: rtl/mem_arb_pkg.sv
// Shared state encoding, byte-enable constants and the alignment check for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;

  // Byte accesses can never be misaligned; halves need addr[0] clear, words addr[1:0] clear.
  function automatic logic is_misaligned(input logic is_byte, input logic is_half,
                                         input logic [1:0] addr_lo);
    if (is_byte) return 1'b0;
    if (is_half) return addr_lo[0];
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store data replication, load lane extraction/extension.
module mem_lane_align import mem_arb_pkg::*; (
  input  logic        i_byte,
  input  logic        i_half,
  input  logic        i_sext,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  // Word accesses are always aligned here, so the shifted word equals the raw word.
  always_comb begin
    w_lane  = i_rdata >> {i_addr_lo, 3'b000};
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    o_rdata = w_lane;
    if (i_byte) begin
      o_be    = 4'b0001 << i_addr_lo;
      o_wdata = {4{i_wdata[7:0]}};
      o_rdata = {{24{i_sext & w_lane[7]}}, w_lane[7:0]};
    end else if (i_half) begin
      o_be    = BE_HALF0 << i_addr_lo;
      o_wdata = {2{i_wdata[15:0]}};
      o_rdata = {{16{i_sext & w_lane[15]}}, w_lane[15:0]};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data; data wins, fetch forced after MAX_D_STREAK.
// Define MEM_ARB_STATS_EN to add the conflict / fetch-wait / forced-grant counters.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int MAX_D_STREAK = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic              d_half,
  input  logic              d_signextend,
  input  logic              d_sc_mask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_conflicts,
  output logic [31:0]       stat_i_wait,
  output logic [31:0]       stat_forced
`endif
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          r_state;
  logic [STREAK_W-1:0] r_streak;
  logic                r_we, r_byte, r_half, r_sext;
  logic [1:0]          r_addr_lo;

  logic        w_streak_full, w_grant_d, w_grant_i, w_misalign;
  logic        w_la_byte, w_la_half, w_la_sext;
  logic [1:0]  w_la_addr_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata;
  logic        w_unused_addr;

  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_grant_d     = (r_state == IDLE) && d_req && !(i_req && w_streak_full);
  assign w_grant_i     = (r_state == IDLE) && i_req && !w_grant_d;
  assign w_misalign    = is_misaligned(d_byte, d_half, d_addr[1:0]);
  assign w_unused_addr = &{1'b0, i_addr[1:0]};

  // Steer from live inputs at grant time, from the latched request while waiting on memory.
  assign w_la_byte    = (r_state == IDLE) ? d_byte       : r_byte;
  assign w_la_half    = (r_state == IDLE) ? d_half       : r_half;
  assign w_la_sext    = (r_state == IDLE) ? d_signextend : r_sext;
  assign w_la_addr_lo = (r_state == IDLE) ? d_addr[1:0]  : r_addr_lo;

  mem_lane_align u_lane_align (
    .i_byte    (w_la_byte),
    .i_half    (w_la_half),
    .i_sext    (w_la_sext),
    .i_addr_lo (w_la_addr_lo),
    .i_wdata   (d_wdata),
    .i_rdata   (mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_streak  <= '0;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_half    <= 1'b0;
      r_sext    <= 1'b0;
      r_addr_lo <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_req) r_streak <= '0;
          if (w_grant_d) begin
            r_we      <= d_we;
            r_byte    <= d_byte;
            r_half    <= d_half;
            r_sext    <= d_signextend;
            r_addr_lo <= d_addr[1:0];
            if (i_req && !w_streak_full) r_streak <= r_streak + 1'b1;
            if (w_misalign) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
              r_state <= DONE;
            end else if (d_we && d_sc_mask) begin
              d_ack   <= 1'b1;
              r_state <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
              r_state   <= BUSY_D;
            end
          end else if (w_grant_i) begin
            r_streak  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= BE_WORD;
            mem_wdata <= '0;
            r_state   <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_ack   <= 1'b1;
            r_state <= DONE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!r_we) d_rdata <= w_rdata;
            d_ack   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflicts <= '0;
      stat_i_wait    <= '0;
      stat_forced    <= '0;
    end else begin
      if ((r_state == IDLE) && i_req && d_req) stat_conflicts <= stat_conflicts + 32'd1;
      if (i_req && !i_ack) stat_i_wait <= stat_i_wait + 32'd1;
      if (w_grant_i && d_req) stat_forced <= stat_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: data vector table with scoreboard, plus fetch,
// arbitration-order and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_byte, d_half, d_signextend, d_sc_mask;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_err;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_i_wait, stat_forced;
`endif

  int          tb_wait;
  logic [31:0] tb_rdata;
  int          r_wcnt = 0;

  always #5 clk = ~clk;

  assign mem_ready = mem_req && (r_wcnt >= tb_wait);
  assign mem_rdata = tb_rdata;
  always @(posedge clk) r_wcnt <= (mem_req && !mem_ready) ? r_wcnt + 1 : 0;

  mem_port_arbiter #(.MAX_D_STREAK(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_half(d_half),
    .d_signextend(d_signextend), .d_sc_mask(d_sc_mask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_i_wait(stat_i_wait), .stat_forced(stat_forced)
`endif
  );

  typedef struct {
    logic        we, byt, half, sext, sc;
    logic [31:0] addr, wdata, rdata;
    int          wt;
    logic        exp_mem;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
    logic        chk_rd, exp_err;
  } vec_t;

  vec_t       vt[16];
  vec_t       dq[$];
  vec_t       mv;
  logic [7:0] ord[$];
  logic [7:0] oe;
  bit         order_mode = 1'b0;
  bit         mem_seen   = 1'b0;
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard side: compares memory-side fields and ack results against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) mem_seen = 1'b1;
      if (!order_mode) begin
        if (mem_req && mem_ready && dq.size() > 0) begin
          check("d_mem_addr", mem_addr, dq[0].addr & 32'hFFFF_FFFC);
          check("d_mem_be", {28'd0, mem_be}, {28'd0, dq[0].exp_be});
          check("d_mem_we", {31'd0, mem_we}, {31'd0, dq[0].we});
          if (dq[0].we) check("d_mem_wdata", mem_wdata, dq[0].exp_wdata);
        end
        if (d_ack) begin
          if (dq.size() == 0) begin
            check("d_ack_unexpected", {31'd0, d_ack}, 32'd0);
          end else begin
            mv = dq.pop_front();
            check("d_err", {31'd0, d_err}, {31'd0, mv.exp_err});
            check("d_mem_used", {31'd0, mem_seen}, {31'd0, mv.exp_mem});
            if (mv.chk_rd) check("d_rdata", d_rdata, mv.exp_rdata);
          end
        end
      end else if (i_ack || d_ack) begin
        if (ord.size() == 0) begin
          check("order_extra_ack", {31'd0, i_ack | d_ack}, 32'd0);
        end else begin
          oe = ord.pop_front();
          check("grant_order", {24'd0, (i_ack ? 8'h49 : 8'h44)}, {24'd0, oe});
        end
      end
      if (i_ack && d_ack) check("ack_overlap", {31'd0, i_ack & d_ack}, 32'd0);
    end
  end

  task automatic do_data(input vec_t v);
    bit got;
    @(negedge clk);
    d_we = v.we; d_byte = v.byt; d_half = v.half; d_signextend = v.sext;
    d_sc_mask = v.sc; d_addr = v.addr; d_wdata = v.wdata;
    tb_rdata = v.rdata; tb_wait = v.wt;
    mem_seen = 1'b0;
    dq.push_back(v);
    d_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_ack) begin got = 1'b1; break; end
    end
    d_req = 1'b0;
    check("d_ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] rd, input int wt, input bit chk_lat);
    bit got;
    int lat;
    @(negedge clk);
    i_addr = a; tb_rdata = rd; tb_wait = wt; i_req = 1'b1;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        check("i_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("i_mem_be", {28'd0, mem_be}, 32'h0000_000F);
        check("i_mem_we", {31'd0, mem_we}, 32'd0);
      end
      if (i_ack) begin got = 1'b1; lat = c; break; end
    end
    i_req = 1'b0;
    check("i_ack_seen", {31'd0, got}, 32'd1);
    if (got) check("i_rdata", i_rdata, rd);
    if (chk_lat) check("i_latency", lat, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] seq;
    bit got;

    //        we    byt   half  sext  sc    addr        wdata         rdata         wt mem   be       exp_wdata     exp_rdata     chk   err
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h203, 32'h0000_0000, 32'h80AA_BBCC, 0, 1'b1, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 32'h0000_0000, 32'h80AA_BBCC, 1, 1'b1, 4'b1000, 32'h0000_0000, 32'h0000_0080, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h302, 32'h1234_ABCD, 32'h0000_0000, 2, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h202, 32'h0000_0000, 32'h80AA_BBCC, 0, 1'b1, 4'b1100, 32'h0000_0000, 32'hFFFF_80AA, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0000_0000, 32'h1234_F00D, 1, 1'b1, 4'b0011, 32'h0000_0000, 32'h0000_F00D, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0000_0000, 32'hDEAD_BEEF, 2, 1'b1, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0000_00A5, 32'h0000_0000, 0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'hCAFE_BABE, 32'h0000_0000, 1, 1'b1, 4'b1111, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h401, 32'h0000_0000, 32'h1111_1111, 0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h403, 32'h0000_0000, 32'h1111_1111, 0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'h1111_1111, 32'h0000_0000, 0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h201, 32'h0000_0000, 32'h80AA_BBCC, 2, 1'b1, 4'b0010, 32'h0000_0000, 32'hFFFF_FFBB, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h301, 32'h0000_BEEF, 32'h0000_0000, 0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h202, 32'h0000_0000, 32'h80AA_BBCC, 1, 1'b1, 4'b1100, 32'h0000_0000, 32'h0000_80AA, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h103, 32'h0000_005A, 32'h0000_0000, 2, 1'b1, 4'b1000, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0000_0000, 32'h0000_007F, 0, 1'b1, 4'b0001, 32'h0000_0000, 32'h0000_007F, 1'b1, 1'b0};

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_half = 1'b0;
    d_signextend = 1'b0; d_sc_mask = 1'b0; d_addr = '0; d_wdata = '0;
    tb_wait = 0; tb_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we},  32'd0);
    check("rst_mem_be",    {28'd0, mem_be},  32'd0);
    check("rst_i_ack",     {31'd0, i_ack},   32'd0);
    check("rst_d_ack",     {31'd0, d_ack},   32'd0);
    check("rst_d_err",     {31'd0, d_err},   32'd0);
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_rdata",   i_rdata,   32'd0);
    check("rst_d_rdata",   d_rdata,   32'd0);

    do_fetch(32'h0000_0100, 32'h1122_3344, 0, 1'b1);
    do_fetch(32'h0000_0A03, 32'h5566_7788, 2, 1'b0);

    for (int i = 0; i < 16; i++) do_data(vt[i]);

    // Both requesters held continuously: four data grants, then a forced fetch, repeating.
    @(negedge clk);
    seq = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) ord.push_back(seq[79 - 8*i -: 8]);
    order_mode = 1'b1;
    d_we = 1'b0; d_byte = 1'b0; d_half = 1'b0; d_sc_mask = 1'b0; d_addr = 32'h400;
    i_addr = 32'h100; tb_wait = 0; tb_rdata = 32'h0BAD_F00D;
    d_req = 1'b1; i_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ord.size() == 0) begin got = 1'b1; break; end
    end
    d_req = 1'b0; i_req = 1'b0;
    check("order_complete", {31'd0, got}, 32'd1);
    repeat (2) @(negedge clk);
    order_mode = 1'b0;

    // Reset while a data load is stalled on memory.
    @(negedge clk);
    d_we = 1'b0; d_byte = 1'b0; d_half = 1'b0; d_sc_mask = 1'b0; d_addr = 32'h600;
    tb_wait = 1000; d_req = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy_mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_no_i_ack", {31'd0, i_ack}, 32'd0);
    rst_n = 1'b1;
    tb_wait = 0;
    repeat (3) @(negedge clk);
    check("post_rst_no_ack", {31'd0, d_ack | i_ack}, 32'd0);
    do_fetch(32'h0000_0100, 32'h7766_5544, 0, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
